// File: rtl/cmp_seq_ctrl_pkg.sv
// Shared constants for the nibble-serial magnitude comparator controller.
package cmp_seq_ctrl_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/cmp_seq_ctrl_cmp4.sv
// Combinational 4-bit unsigned magnitude comparator, the shared compare resource.
module cmp_4bit
  import cmp_seq_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  output logic             lth_c,
  output logic             equ_c,
  output logic             gth_c
);

  assign lth_c = (a < b);
  assign equ_c = (a == b);
  assign gth_c = (a > b);

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Multi-cycle 4N-bit magnitude comparator: walks operand nibbles MSB first
// through one cmp_4bit, stopping at the first unequal nibble.
module cmp_seq_ctrl
  import cmp_seq_ctrl_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  input  logic           sgn,
  input  logic [4*N-1:0] x,
  input  logic [4*N-1:0] y,
  output logic           ack,
  output logic           busy,
  output logic           lth,
  output logic           equ,
  output logic           gth
);

  localparam int unsigned W  = NIB_W * N;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  state_t         state, state_nx;
  logic [W-1:0]   xs, ys, xs_nx, ys_nx;
  logic           sg, sg_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic           ack_nx, busy_nx, lth_nx, equ_nx, gth_nx;
  logic           first;
  logic [NIB_W-1:0] nib_x, nib_y;
  logic           c_lth, c_equ, c_gth;

  // Offset-binary trick: flipping the sign bit of the top nibble makes
  // an unsigned compare order two's-complement values correctly.
  assign first = (cnt == CW'(N - 1));
  assign nib_x = xs[W-1 -: NIB_W] ^ {(sg & first), 3'b000};
  assign nib_y = ys[W-1 -: NIB_W] ^ {(sg & first), 3'b000};

  cmp_4bit u_cmp (
    .a     (nib_x),
    .b     (nib_y),
    .lth_c (c_lth),
    .equ_c (c_equ),
    .gth_c (c_gth)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      xs    <= '0;
      ys    <= '0;
      sg    <= 1'b0;
      cnt   <= '0;
      ack   <= 1'b0;
      busy  <= 1'b0;
      lth   <= 1'b0;
      equ   <= 1'b0;
      gth   <= 1'b0;
    end else begin
      state <= state_nx;
      xs    <= xs_nx;
      ys    <= ys_nx;
      sg    <= sg_nx;
      cnt   <= cnt_nx;
      ack   <= ack_nx;
      busy  <= busy_nx;
      lth   <= lth_nx;
      equ   <= equ_nx;
      gth   <= gth_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (req) state_nx = ST_RUN;
      ST_RUN:  if (c_lth || c_gth || (cnt == '0)) state_nx = ST_DONE;
      ST_DONE: if (!req) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    xs_nx   = xs;
    ys_nx   = ys;
    sg_nx   = sg;
    cnt_nx  = cnt;
    lth_nx  = lth;
    equ_nx  = equ;
    gth_nx  = gth;
    busy_nx = (state_nx == ST_RUN);
    ack_nx  = (state_nx == ST_DONE);
    case (state)
      ST_IDLE: begin
        if (req) begin
          xs_nx  = x;
          ys_nx  = y;
          sg_nx  = sgn;
          cnt_nx = CW'(N - 1);
          lth_nx = 1'b0;
          equ_nx = 1'b0;
          gth_nx = 1'b0;
        end
      end
      ST_RUN: begin
        if (c_lth || c_gth) begin
          lth_nx = c_lth;
          gth_nx = c_gth;
        end else if (cnt == '0) begin
          equ_nx = c_equ;
        end else begin
          xs_nx  = xs << NIB_W;
          ys_nx  = ys << NIB_W;
          cnt_nx = cnt - CW'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Directed self-checking bench for cmp_seq_ctrl (N=4 and N=1 instances).
module tb_cmp_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req4 = 1'b0, sgn4 = 1'b0;
  logic [15:0] x4 = '0, y4 = '0;
  logic        ack4, busy4, lth4, equ4, gth4;

  logic        req1 = 1'b0, sgn1 = 1'b0;
  logic [3:0]  x1 = '0, y1 = '0;
  logic        ack1, busy1, lth1, equ1, gth1;

  cmp_seq_ctrl #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .sgn(sgn4), .x(x4), .y(y4),
    .ack(ack4), .busy(busy4), .lth(lth4), .equ(equ4), .gth(gth4)
  );

  cmp_seq_ctrl #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .sgn(sgn1), .x(x1), .y(y1),
    .ack(ack1), .busy(busy1), .lth(lth1), .equ(equ1), .gth(gth1)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sg;
    logic [15:0] x;
    logic [15:0] y;
    logic [2:0]  flags;   // {lth, equ, gth}
    int          lat;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issues one request on the N=4 instance, measures latency, checks flags,
  // single-cycle ack and flag hold in IDLE. Optionally corrupts x after capture.
  task automatic run4(input string nm, input logic sg, input logic [15:0] xa,
                      input logic [15:0] ya, input logic [2:0] fl, input int lat,
                      input logic corrupt);
    int n;
    @(negedge clk);
    x4 = xa; y4 = ya; sgn4 = sg; req4 = 1'b1;
    @(posedge clk); #1;
    req4 = 1'b0;
    chk({nm, " busy"}, 32'(busy4), 32'd1);
    n = 0;
    while (!ack4 && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (corrupt && n == 1) begin
        x4 = 16'hFFFF; y4 = 16'h0000; sgn4 = ~sg;
      end
    end
    chk({nm, " latency"}, 32'(n), 32'(lat));
    chk({nm, " flags"}, 32'({lth4, equ4, gth4}), 32'(fl));
    @(posedge clk); #1;
    chk({nm, " ack drop"}, 32'(ack4), 32'd0);
    chk({nm, " flag hold"}, 32'({lth4, equ4, gth4}), 32'(fl));
  endtask

  task automatic run1(input string nm, input logic sg, input logic [3:0] xa,
                      input logic [3:0] ya, input logic [2:0] fl);
    int n;
    @(negedge clk);
    x1 = xa; y1 = ya; sgn1 = sg; req1 = 1'b1;
    @(posedge clk); #1;
    req1 = 1'b0;
    chk({nm, " busy"}, 32'(busy1), 32'd1);
    n = 0;
    while (!ack1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, 32'(n), 32'd1);
    chk({nm, " flags"}, 32'({lth1, equ1, gth1}), 32'(fl));
    @(posedge clk); #1;
    chk({nm, " ack drop"}, 32'(ack1), 32'd0);
  endtask

  initial begin
    tbl[0] = '{1'b0, 16'h1234, 16'h1234, 3'b010, 4};
    tbl[1] = '{1'b0, 16'h8000, 16'h7FFF, 3'b001, 1};
    tbl[2] = '{1'b1, 16'h8000, 16'h7FFF, 3'b100, 1};
    tbl[3] = '{1'b0, 16'h12A4, 16'h12B4, 3'b100, 3};
    tbl[4] = '{1'b0, 16'h0010, 16'h0100, 3'b100, 2};
    tbl[5] = '{1'b1, 16'hFFFF, 16'h0001, 3'b100, 1};
    tbl[6] = '{1'b1, 16'hF123, 16'hF124, 3'b100, 4};
    tbl[7] = '{1'b0, 16'h0001, 16'h0000, 3'b001, 4};
    tbl[8] = '{1'b1, 16'h8000, 16'h8001, 3'b100, 4};

    repeat (3) @(posedge clk);
    #1;
    chk("reset outs4", 32'({ack4, busy4, lth4, equ4, gth4}), 32'd0);
    chk("reset outs1", 32'({ack1, busy1, lth1, equ1, gth1}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 9; i++)
      run4($sformatf("vec%0d", i), tbl[i].sg, tbl[i].x, tbl[i].y,
           tbl[i].flags, tbl[i].lat, 1'b0);

    // Operands changing after capture must not disturb the compare.
    run4("late_x", 1'b0, 16'h12A4, 16'h12B4, 3'b100, 3, 1'b1);

    // Asynchronous reset mid-operation, then a clean compare.
    @(negedge clk);
    x4 = 16'h0001; y4 = 16'h0000; sgn4 = 1'b0; req4 = 1'b1;
    @(posedge clk); #1;
    req4 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("busy before rst", 32'(busy4), 32'd1);
    rst = 1'b0;
    #1;
    chk("async rst outs", 32'({ack4, busy4, lth4, equ4, gth4}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle after rst", 32'({ack4, busy4}), 32'd0);
    run4("post_rst", 1'b0, 16'h0001, 16'h0000, 3'b001, 4, 1'b0);

    // Held req: ack stays high and no second capture occurs.
    @(negedge clk);
    x4 = 16'h5555; y4 = 16'h5555; sgn4 = 1'b0; req4 = 1'b1;
    @(posedge clk); #1;
    x4 = 16'h0000; y4 = 16'hFFFF;
    repeat (4) @(posedge clk);
    #1;
    chk("hold first ack", 32'(ack4), 32'd1);
    begin
      int bad = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (!ack4 || busy4 || !equ4) bad++;
      end
      chk("hold req stable", 32'(bad), 32'd0);
    end
    req4 = 1'b0;
    @(posedge clk); #1;
    chk("hold ack drop", 32'(ack4), 32'd0);
    chk("hold equ kept", 32'({lth4, equ4, gth4}), 32'b010);
    run4("hs_new", 1'b0, 16'h0010, 16'h0100, 3'b100, 2, 1'b0);

    // N=1 instance: sign inversion on the only nibble.
    run1("n1_neg1_lt_1", 1'b1, 4'hF, 4'h1, 3'b100);
    run1("n1_7_gt_neg8", 1'b1, 4'h7, 4'h8, 3'b001);
    run1("n1_unsigned", 1'b0, 4'hF, 4'h1, 3'b001);
    run1("n1_equal", 1'b1, 4'hA, 4'hA, 3'b010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
